// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM driver: dead-time FSM state encoding and
// the terminal value of the 255-tick period counter.
package pwm_pkg;

  // Period counter runs 0..PERIOD_MAX, giving a 255-tick period.
  localparam int unsigned PERIOD_MAX = 254;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO_ON,
    ST_DEAD_H,
    ST_HI_ON,
    ST_DEAD_L
  } dt_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time generator: turns the raw PWM level into complementary
// high-side/low-side drives with DEAD_CYCLES of both-off at every edge.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   enable    - run when high; forces IDLE (both off) when low
//   raw       - raw PWM level (1 = high side wanted)
//   pwm_hi    - registered high-side drive
//   pwm_lo    - registered low-side drive
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic raw,
  output logic pwm_hi,
  output logic pwm_lo
);

  localparam logic [3:0] DEAD_LAST = 4'(DEAD_CYCLES - 1);

  dt_state_e  state_q;
  logic [3:0] dcnt_q;
  logic       hi_q;
  logic       lo_q;

  // Outputs are decoded from the state being entered, so each drive is a
  // flop and the two can never be high together.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_LO_ON: begin
          if (raw) begin
            state_q <= ST_DEAD_H;
            dcnt_q  <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
          end else begin
            state_q <= ST_LO_ON;
            hi_q    <= 1'b0;
            lo_q    <= 1'b1;
          end
        end
        ST_DEAD_H: begin
          // A raw pulse shorter than the dead time falls back to the low side.
          if (!raw) begin
            state_q <= ST_LO_ON;
            lo_q    <= 1'b1;
          end else if (dcnt_q == DEAD_LAST) begin
            state_q <= ST_HI_ON;
            hi_q    <= 1'b1;
          end else begin
            dcnt_q  <= dcnt_q + 4'd1;
          end
        end
        ST_HI_ON: begin
          if (!raw) begin
            state_q <= ST_DEAD_L;
            dcnt_q  <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
          end
        end
        ST_DEAD_L: begin
          if (raw) begin
            state_q <= ST_HI_ON;
            hi_q    <= 1'b1;
          end else if (dcnt_q == DEAD_LAST) begin
            state_q <= ST_LO_ON;
            lo_q    <= 1'b1;
          end else begin
            dcnt_q  <= dcnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          dcnt_q  <= '0;
          hi_q    <= 1'b0;
          lo_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_hi = hi_q;
  assign pwm_lo = lo_q;

endmodule

// File: rtl/pwm_driver.sv
// 8-bit PWM driver with prescaler, 255-tick period, double-buffered duty
// word (valid/ready handshake, loaded at period wrap or enable rise) and
// complementary dead-time outputs.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   duty_in       - new duty word
//   duty_valid    - duty_in valid
//   duty_ready    - shadow register free (no word pending)
//   enable        - run PWM; outputs forced off when low
//   pwm_hi/pwm_lo - registered complementary drives
//   period_start  - one-clk pulse at each period start
//   duty_active   - duty word currently in effect
module pwm_driver
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE    = 4,
  parameter int unsigned DEAD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  input  logic       enable,
  output logic       pwm_hi,
  output logic       pwm_lo,
  output logic       period_start,
  output logic [7:0] duty_active
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  CNT_LAST   = 8'(PERIOD_MAX);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        en_q;
  logic        pending_q, pending_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [7:0]  active_q, active_d;
  logic        ps_q, ps_d;

  logic run, rise, tick, wrap, load, xfer, raw;

  always_comb begin
    // Counters only advance once enable has been high for a full clk, so the
    // cycle after an enable rise shows cnt = 0 alongside period_start.
    run  = enable & en_q;
    rise = enable & ~en_q;
    tick = run && (presc_q == PRESC_LAST);
    wrap = tick && (cnt_q == CNT_LAST);

    presc_d = '0;
    cnt_d   = '0;
    if (run) begin
      presc_d = tick ? '0 : presc_q + 16'd1;
      cnt_d   = tick ? (wrap ? '0 : cnt_q + 8'd1) : cnt_q;
    end

    ps_d = wrap | rise;
    load = ps_d & pending_q;
    xfer = duty_valid & ~pending_q;

    pending_d = pending_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    // load needs pending, xfer needs !pending: never both in one clk, so a
    // word accepted on a wrap clk waits for the following wrap.
    if (load) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (xfer) begin
      shadow_d  = duty_in;
      pending_d = 1'b1;
    end

    raw = cnt_q < active_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      ps_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      en_q      <= enable;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      ps_q      <= ps_d;
    end
  end

  pwm_deadtime #(
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_deadtime (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .raw   (raw),
    .pwm_hi(pwm_hi),
    .pwm_lo(pwm_lo)
  );

  assign duty_ready   = ~pending_q;
  assign duty_active  = active_q;
  assign period_start = ps_q;

endmodule

// File: doc/pwm_driver.md
PWM_DRIVER -- requirements
Module: pwm_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, meaning clk cycles per PWM tick (range 1..65535).
REQ-002 SHALL have parameter DEAD_CYCLES, default 3, meaning clk cycles with both outputs off at each edge (range 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port duty_in  input  8  new duty word, fed by the PID control output.
REQ-006 SHALL have port duty_valid  input  1  duty_in is valid.
REQ-007 SHALL have port duty_ready  output  1  shadow register can accept a duty word.
REQ-008 SHALL have port enable  input  1  run PWM when high; outputs forced off when low.
REQ-009 SHALL have port pwm_hi  output  1  high-side drive, registered.
REQ-010 SHALL have port pwm_lo  output  1  low-side drive, complementary to pwm_hi with dead time, registered.
REQ-011 SHALL have port period_start  output  1  one-clk pulse at each period start; the PID sample strobe.
REQ-012 SHALL have port duty_active  output  8  duty word currently in effect.

Function
REQ-013 Prescaler SHALL count 0..PRESCALE-1 and assert an internal tick on terminal count; held at 0 while enable low.
REQ-014 Period counter cnt SHALL advance 0..254 on each tick and wrap 254->0; period = 255 ticks; held at 0 while enable low.
REQ-015 Raw PWM SHALL be (cnt < duty_active); duty 0 = always low, duty 255 = always high.
REQ-016 Handshake: transfer when duty_valid && duty_ready; duty_in captured into shadow, pending flag set next clk.
REQ-017 duty_ready SHALL equal !pending; one-entry buffer, no overwrite of a pending word.
REQ-018 At wrap (cnt 254->0), or on enable rising edge, pending shadow SHALL load into duty_active and clear pending in the same clk.
REQ-019 Transfer on the same clk as a wrap (pending was 0) SHALL take effect at the following wrap, not the current one.
REQ-020 period_start SHALL pulse for one clk on the clk cnt becomes 0 by wrap, and on the first clk after enable rises.
REQ-021 Dead-time FSM states: IDLE, LO_ON, DEAD_H, HI_ON, DEAD_L.
REQ-022 IDLE: both outputs 0; enable high -> LO_ON if raw=0, else DEAD_H.
REQ-023 LO_ON: pwm_lo=1; raw=1 -> DEAD_H.
REQ-024 DEAD_H: both 0; after DEAD_CYCLES clks -> HI_ON; raw=0 before expiry -> LO_ON.
REQ-025 HI_ON: pwm_hi=1; raw=0 -> DEAD_L.
REQ-026 DEAD_L: both 0; after DEAD_CYCLES clks -> LO_ON; raw=1 before expiry -> HI_ON.
REQ-027 enable low in any state SHALL force IDLE next clk; shadow and handshake keep operating.
REQ-028 pwm_hi and pwm_lo SHALL never both be 1 in any cycle, including reset and enable toggles.
REQ-029 Output latency: raw change visible on outputs 1 clk after the state entered; no combinational path input->output.

Reset
REQ-030 On rst high at a clk edge: pwm_hi=0, pwm_lo=0, period_start=0, duty_active=0, duty_ready=1, pending=0, counters 0, FSM IDLE.
REQ-031 rst mid-period or mid-dead-time SHALL abort immediately; any pending word SHALL be discarded.
REQ-032 rst SHALL take priority over enable and handshake in the same cycle.

Structure
REQ-033 Package pwm_pkg SHALL hold the FSM state enum and constant PERIOD_MAX=254.
REQ-034 Dead-time FSM and its counter SHALL be sub-module pwm_deadtime (in: clk, rst, enable, raw; out: pwm_hi, pwm_lo).
REQ-035 Top level holds prescaler, period counter, shadow/handshake and period_start.

Verification (PRESCALE=1, DEAD_CYCLES=3)
REQ-036 rst, enable=1, send duty 128 -> from next period, raw high 128 of 255 clks; pwm_hi high 125 clks, pwm_lo high 124 clks, 3-clk gaps.
REQ-037 duty 0 then 255 -> pwm_lo constant 1 over full period; next period pwm_hi constant 1 after one 3-clk dead gap.
REQ-038 Send 40 then 200 back-to-back -> duty_ready low after first transfer until wrap; duty_active 40 then 200 on consecutive wraps.
REQ-039 duty 2 -> raw high 2 clks < DEAD_CYCLES; pwm_hi never 1, DEAD_H returns to LO_ON; pwm_hi & pwm_lo never both 1.
REQ-040 enable low mid-HI_ON at cnt 60 -> both outputs 0 next clk; re-enable -> period_start pulse, cnt restarts 0.
REQ-041 rst at cnt 100 with pending word 77 -> all outputs reset values next clk, duty_active 0, word 77 discarded.
